// File: rtl/demux_1ton_stream.sv
// 1-to-N stream demultiplexer with one output register per channel, unicast or
// all-or-nothing broadcast, and a free-running completed-transfer counter per channel.
module demux_1ton_stream #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH),
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_bcast,
   output logic [NUM_CH-1:0]       out_valid,
   input  logic [NUM_CH-1:0]       out_ready,
   output logic [NUM_CH*WIDTH-1:0] out_data,
   output logic [NUM_CH*CNT_W-1:0] xfer_cnt
);

   logic [NUM_CH-1:0]       valid_q, valid_d;
   logic [NUM_CH*WIDTH-1:0] data_q, data_d;
   logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]       free;
   logic [NUM_CH-1:0]       load;
   logic [NUM_CH-1:0]       out_xfer;
   logic                    in_xfer;

   assign free     = ~valid_q | out_ready;
   assign out_xfer = valid_q & out_ready;

   // Broadcast needs every channel free so a word is never delivered to only some of them.
   assign in_ready = rst_n & (in_bcast ? (&free) : free[in_sel]);
   assign in_xfer  = in_valid & in_ready;

   always_comb begin
      load    = '0;
      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         load[i] = in_xfer & (in_bcast | (in_sel == SEL_W'(i)));
         if (load[i]) begin
            valid_d[i]                 = 1'b1;
            data_d[i*WIDTH +: WIDTH]   = in_data;
         end else if (out_xfer[i]) begin
            valid_d[i]                 = 1'b0;
         end
         if (out_xfer[i]) begin
            cnt_d[i*CNT_W +: CNT_W]    = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Directed bench for demux_1ton_stream (WIDTH=8, NUM_CH=4, CNT_W=4 so the counter wrap is reachable).
module tb_demux_1ton_stream;

   localparam int WIDTH  = 8;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;
   localparam int CNT_W  = 4;

   logic                    clk;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        in_data;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_bcast;
   logic [NUM_CH-1:0]       out_valid;
   logic [NUM_CH-1:0]       out_ready;
   logic [NUM_CH*WIDTH-1:0] out_data;
   logic [NUM_CH*CNT_W-1:0] xfer_cnt;

   int vectors     = 0;
   int miscompares = 0;

   demux_1ton_stream #(
      .WIDTH (WIDTH),
      .NUM_CH(NUM_CH),
      .SEL_W (SEL_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_bcast (in_bcast),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .xfer_cnt (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] dat(input int ch);
      return out_data[ch*WIDTH +: WIDTH];
   endfunction

   function automatic logic [CNT_W-1:0] cnt(input int ch);
      return xfer_cnt[ch*CNT_W +: CNT_W];
   endfunction

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_sel    = '0;
      in_bcast  = 1'b0;
      out_ready = '0;
      tick();
      tick();

      // reset state; in_ready must stay low during reset even with a request pending
      in_valid = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      // unicast sweep, first accept in the first cycle out of reset
      out_ready = 4'b1111;
      for (int s = 0; s < NUM_CH; s++) begin
         in_valid = 1'b1;
         in_sel   = SEL_W'(s);
         in_data  = 8'hA5;
         #1;
         chk($sformatf("sweep_in_ready_%0d", s), 32'(in_ready), 32'h1);
         tick();
         chk($sformatf("sweep_out_valid_%0d", s), 32'(out_valid), 32'(4'b0001 << s));
         chk($sformatf("sweep_data_%0d", s), 32'(dat(s)), 32'hA5);
      end
      in_valid = 1'b0;
      tick();
      chk("sweep_drained", 32'(out_valid), 32'h0);
      for (int s = 0; s < NUM_CH; s++)
         chk($sformatf("sweep_cnt_%0d", s), 32'(cnt(s)), 32'h1);

      // stall and hold on channel 2
      out_ready = 4'b1011;
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      in_data   = 8'h11;
      #1;
      chk("stall_first_ready", 32'(in_ready), 32'h1);
      tick();
      in_data = 8'h22;
      #1;
      chk("stall_second_blocked", 32'(in_ready), 32'h0);
      tick();
      chk("stall_hold_data", 32'(dat(2)), 32'h11);
      chk("stall_hold_valid", 32'(out_valid), 32'b0100);

      // stall isolation: channel 1 still reachable
      in_sel  = 2'd1;
      in_data = 8'h33;
      #1;
      chk("iso_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("iso_data1", 32'(dat(1)), 32'h33);
      chk("iso_valid", 32'(out_valid), 32'b0110);

      in_sel  = 2'd2;
      in_data = 8'h22;
      #1;
      chk("stall_still_blocked", 32'(in_ready), 32'h0);
      chk("stall_still_11", 32'(dat(2)), 32'h11);
      out_ready = 4'b1111;
      #1;
      chk("stall_release_ready", 32'(in_ready), 32'h1);
      tick();
      chk("stall_reload_data", 32'(dat(2)), 32'h22);
      chk("stall_reload_valid", 32'(out_valid), 32'b0100);
      in_valid = 1'b0;
      tick();
      chk("stall_drained", 32'(out_valid), 32'h0);
      chk("stall_cnt2", 32'(cnt(2)), 32'h3);
      chk("stall_cnt1", 32'(cnt(1)), 32'h2);

      // broadcast blocked by a full, stalled channel 3
      out_ready = 4'b0111;
      in_valid  = 1'b1;
      in_sel    = 2'd3;
      in_data   = 8'h77;
      tick();
      in_bcast = 1'b1;
      in_sel   = 2'd0;
      in_data  = 8'h5A;
      #1;
      chk("bcast_blocked_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bcast_no_partial", 32'(out_valid), 32'b1000);
      chk("bcast_ch0_untouched", 32'(dat(0)), 32'hA5);
      chk("bcast_ch3_held", 32'(dat(3)), 32'h77);
      out_ready = 4'b1111;
      #1;
      chk("bcast_ready", 32'(in_ready), 32'h1);
      tick();
      chk("bcast_all_valid", 32'(out_valid), 32'b1111);
      chk("bcast_all_data", 32'(out_data), 32'h5A5A5A5A);
      in_valid = 1'b0;
      in_bcast = 1'b0;
      tick();
      chk("bcast_drained", 32'(out_valid), 32'h0);
      chk("bcast_cnt0", 32'(cnt(0)), 32'h2);
      chk("bcast_cnt3", 32'(cnt(3)), 32'h3);

      // back-to-back on channel 0 from fresh counters
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_sel   = 2'd0;
         in_data  = 8'(8'h10 + k);
         #1;
         chk($sformatf("b2b_ready_%0d", k), 32'(in_ready), 32'h1);
         tick();
         chk($sformatf("b2b_valid_%0d", k), 32'(out_valid), 32'b0001);
         chk($sformatf("b2b_data_%0d", k), 32'(dat(0)), 32'(8'h10 + k));
      end
      in_valid = 1'b0;
      tick();
      chk("b2b_cnt0", 32'(cnt(0)), 32'd10);

      // counter wrap: 17 transfers into a 4-bit counter
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 17; k++) begin
         in_valid = 1'b1;
         in_sel   = 2'd0;
         in_data  = 8'(k);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("wrap_cnt0", 32'(cnt(0)), 32'h1);

      // reset mid-operation: channel 1 held, channel 0 draining on the reset edge
      out_ready = 4'b1101;
      in_valid  = 1'b1;
      in_sel    = 2'd1;
      in_data   = 8'hC3;
      tick();
      in_sel  = 2'd0;
      in_data = 8'h44;
      tick();
      in_valid = 1'b0;
      chk("prerst_valid", 32'(out_valid), 32'b0011);
      rst_n = 1'b0;
      tick();
      chk("midrst_valid", 32'(out_valid), 32'h0);
      chk("midrst_cnt", 32'(xfer_cnt), 32'h0);
      chk("midrst_data", 32'(out_data), 32'h0);
      rst_n = 1'b1;
      tick();
      chk("postrst_valid", 32'(out_valid), 32'h0);
      chk("postrst_cnt", 32'(xfer_cnt), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
